// File: rtl/kfpga_io_pkg.sv
// Shared helpers and config-word layout for the kfpga IO routing muxes.
// Holds the clog2 helper, config field offsets and padded tree width.
package kfpga_io_pkg;

    // Selector occupies the low bits of the config word.
    localparam int unsigned SEL_LSB = 0;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // out_reg_en sits directly above the selector field.
    function automatic int unsigned out_reg_en_pos(input int unsigned sel_width);
        return sel_width;
    endfunction

    // Tree is padded up to the next power of two.
    function automatic int unsigned tree_width(input int unsigned sel_width);
        return 32'd1 << sel_width;
    endfunction

    // Defaults for the 6-input IO tile flavour.
    localparam int unsigned DEF_DATA_COUNT = 6;
    localparam int unsigned DEF_SEL_WIDTH  = clog2(DEF_DATA_COUNT);
    localparam int unsigned DEF_TREE_WIDTH = tree_width(DEF_SEL_WIDTH);

endpackage

// File: rtl/io_mux_stage.sv
// One level of the 2:1 mux tree: halves the vector, picking the upper half
// when sel=1. Optionally registered; flush loads zero into the register.
// Ports: clock, nreset (async, active-low), flush, sel, in[IN_WIDTH],
//        out[IN_WIDTH/2].
module io_mux_stage #(
    parameter int unsigned IN_WIDTH   = 2,
    parameter bit          REGISTERED = 1'b0
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    flush,
    input  logic                    sel,
    input  logic [IN_WIDTH-1:0]     in,
    output logic [IN_WIDTH/2-1:0]   out
);

    localparam int unsigned HALF = IN_WIDTH / 2;

    logic [HALF-1:0] pick;

    assign pick = sel ? in[IN_WIDTH-1:HALF] : in[HALF-1:0];

    generate
        if (REGISTERED) begin : g_reg
            logic [HALF-1:0] q;

            // Stage register; cleared while the config chain is busy.
            always_ff @(posedge clock or negedge nreset) begin
                if (!nreset) begin
                    q <= '0;
                end else if (flush) begin
                    q <= '0;
                end else begin
                    q <= pick;
                end
            end

            assign out = q;
        end else begin : g_comb
            // Clock/reset/flush have no role in a combinational level.
            logic unused_ctrl;
            assign unused_ctrl = clock ^ nreset ^ flush;
            assign out         = pick;
        end
    endgenerate

endmodule

// File: rtl/io_mux_pipelined.sv
// Parametrised IO-to-IO routing mux: DATA_COUNT inputs reduced by a binary
// tree of 2:1 levels (optionally pipelined), with an optional output register.
// The config word {out_reg_en, selector} is loaded through a serial shift
// chain and committed to the active config when config_enable drops.
// Ports: clock, nreset (async, active-low), data_in[DATA_COUNT], data_out,
//        config_in, config_enable, config_out (serial chain).
module io_mux_pipelined
    import kfpga_io_pkg::*;
#(
    parameter int unsigned DATA_COUNT   = 6,
    parameter int unsigned SEL_WIDTH    = clog2(DATA_COUNT),
    parameter int unsigned PIPELINE     = 0,
    parameter int unsigned CONFIG_WIDTH = SEL_WIDTH + 1
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [DATA_COUNT-1:0] data_in,
    output logic                  data_out,
    input  logic                  config_in,
    input  logic                  config_enable,
    output logic                  config_out
);

    localparam int unsigned TREE_W   = tree_width(SEL_WIDTH);
    localparam int unsigned OREG_POS = out_reg_en_pos(SEL_WIDTH);
    // All tree levels packed back to back: TREE_W + TREE_W/2 + ... + 1 bits.
    localparam int unsigned TREE_BITS = 2 * TREE_W - 1;

    logic [CONFIG_WIDTH-1:0] shift_q;
    logic [CONFIG_WIDTH-1:0] active_q;
    logic                    shifting_q;
    logic                    flush;
    logic [TREE_BITS-1:0]    tree;
    logic                    tree_out;
    logic                    out_q;

    // Pipeline is quiet while shifting and on the commit edge.
    assign flush = config_enable | shifting_q;

    // Config shift chain and commit register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            shift_q    <= '0;
            active_q   <= '0;
            shifting_q <= 1'b0;
        end else if (config_enable) begin
            shift_q    <= {config_in, shift_q[CONFIG_WIDTH-1:1]};
            shifting_q <= 1'b1;
        end else if (shifting_q) begin
            active_q   <= shift_q;
            shifting_q <= 1'b0;
        end
    end

    assign config_out = shift_q[0];

    // Level 0 input: data zero-padded to a power of two.
    assign tree[TREE_W-1:0] = TREE_W'(data_in);

    // Level j halves TREE_W>>j bits using selector bit SEL_WIDTH-1-j.
    generate
        for (genvar j = 0; j < SEL_WIDTH; j++) begin : g_level
            localparam int unsigned IN_W    = TREE_W >> j;
            localparam int unsigned IN_OFF  = 2 * TREE_W - 2 * IN_W;
            localparam int unsigned OUT_OFF = IN_OFF + IN_W;
            localparam int unsigned SEL_BIT = SEL_LSB + SEL_WIDTH - 1 - j;

            io_mux_stage #(
                .IN_WIDTH   (IN_W),
                .REGISTERED (PIPELINE != 0)
            ) u_stage (
                .clock  (clock),
                .nreset (nreset),
                .flush  (flush),
                .sel    (active_q[SEL_BIT]),
                .in     (tree[IN_OFF +: IN_W]),
                .out    (tree[OUT_OFF +: IN_W/2])
            );
        end
    endgenerate

    assign tree_out = tree[TREE_BITS-1];

    // Optional output register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            out_q <= 1'b0;
        end else if (flush) begin
            out_q <= 1'b0;
        end else begin
            out_q <= tree_out;
        end
    end

    // A fully combinational route is gated so it stays 0 in reset and while
    // the chain is being reloaded, like the registered routes.
    always_comb begin
        data_out = tree_out;
        if (active_q[OREG_POS]) begin
            data_out = out_q;
        end else if ((PIPELINE == 0) && (flush || !nreset)) begin
            data_out = 1'b0;
        end
    end

endmodule
